// File: rtl/gshare_param_ongorucu_pkg.sv
// Shared opcode, counter state and immediate decode helpers
// for the gshare branch predictor.
package ongorucu_paket;

    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        GT = 2'd0,
        ZT = 2'd1,
        ZA = 2'd2,
        GA = 2'd3
    } sayac_t;

    function automatic logic [31:0] b_imm(input logic [31:0] b);
        return {{20{b[31]}}, b[7], b[30:25], b[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] b);
        return {{12{b[31]}}, b[19:12], b[20], b[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/gshare_param_ongorucu_doygun_sayac.sv
// Two-bit saturating counter step: up on taken, down on not taken,
// pinned at GA and GT.
module doygun_sayac
    import ongorucu_paket::*;
(
    input  sayac_t durum,
    input  logic   dallan,
    output sayac_t yeni
);

    always_comb begin
        yeni = durum;
        unique case (1'b1)
            dallan && (durum != GA): yeni = sayac_t'(durum + 2'd1);
            !dallan && (durum != GT): yeni = sayac_t'(durum - 2'd1);
            default: yeni = durum;
        endcase
    end

endmodule

// File: rtl/gshare_param_ongorucu.sv
// Gshare conditional branch predictor with speculative global history,
// misprediction repair and prediction/mispredict counters.
module gshare_param_ongorucu
    import ongorucu_paket::*;
#(
    parameter int PHT_IDX_BIT = 6,
    parameter int GGY_BIT     = 6,
    parameter int SAYAC_BIT   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 getir_gecerli,
    input  logic [31:0]          getir_ps,
    input  logic [31:0]          getir_buyruk,
    input  logic                 yurut_gecerli,
    input  logic [31:0]          yurut_ps,
    input  logic [GGY_BIT-1:0]   yurut_ggy,
    input  logic                 yurut_dallan,
    input  logic                 yurut_yanlis,
    output logic                 sonuc_dallan,
    output logic [31:0]          sonuc_dallan_ps,
    output logic [GGY_BIT-1:0]   sonuc_ggy,
    output logic [SAYAC_BIT-1:0] tahmin_sayaci,
    output logic [SAYAC_BIT-1:0] yanlis_sayaci
);

    localparam int PHT_N = 1 << PHT_IDX_BIT;

    sayac_t                 pht [PHT_N];
    sayac_t                 oku_durum;
    sayac_t                 yeni_durum;
    logic [GGY_BIT-1:0]     ggy_q;
    logic [GGY_BIT-1:0]     ggy_d;
    logic [PHT_IDX_BIT-1:0] oku_idx;
    logic [PHT_IDX_BIT-1:0] yaz_idx;
    logic                   is_b;
    logic                   is_j;
    logic                   b_gecerli;
    logic                   onarim;
    logic                   unused;

    assign is_b      = getir_buyruk[6:0] == OP_B;
    assign is_j      = getir_buyruk[6:0] == OP_JAL;
    assign b_gecerli = getir_gecerli && is_b;
    assign onarim    = yurut_gecerli && yurut_yanlis;

    assign oku_idx   = getir_ps[PHT_IDX_BIT+1:2] ^ PHT_IDX_BIT'(ggy_q);
    assign yaz_idx   = yurut_ps[PHT_IDX_BIT+1:2] ^ PHT_IDX_BIT'(yurut_ggy);
    assign oku_durum = pht[oku_idx];
    assign unused    = ^{yurut_ps[31:PHT_IDX_BIT+2], yurut_ps[1:0]};

    always_comb begin
        sonuc_dallan    = 1'b0;
        sonuc_dallan_ps = getir_ps + 32'd4;
        if (getir_gecerli) begin
            unique case (1'b1)
                is_j: begin
                    sonuc_dallan    = 1'b1;
                    sonuc_dallan_ps = getir_ps + j_imm(getir_buyruk);
                end
                is_b && oku_durum[1]: begin
                    sonuc_dallan    = 1'b1;
                    sonuc_dallan_ps = getir_ps + b_imm(getir_buyruk);
                end
                default: ;
            endcase
        end
    end

    // Repair from execute outranks the speculative shift of the same cycle.
    always_comb begin
        ggy_d = ggy_q;
        if (onarim)
            ggy_d = GGY_BIT'({yurut_ggy, yurut_dallan});
        else if (b_gecerli)
            ggy_d = GGY_BIT'({ggy_q, oku_durum[1]});
    end

    assign sonuc_ggy = ggy_q;

    doygun_sayac u_doygun_sayac (
        .durum  (pht[yaz_idx]),
        .dallan (yurut_dallan),
        .yeni   (yeni_durum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_N; i++)
                pht[i] <= ZT;
        end else if (yurut_gecerli) begin
            pht[yaz_idx] <= yeni_durum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ggy_q         <= '0;
            tahmin_sayaci <= '0;
            yanlis_sayaci <= '0;
        end else begin
            ggy_q <= ggy_d;
            if (b_gecerli)
                tahmin_sayaci <= tahmin_sayaci + 1'b1;
            if (onarim)
                yanlis_sayaci <= yanlis_sayaci + 1'b1;
        end
    end

endmodule

// File: tb/tb_gshare_param_ongorucu.sv
// Directed bench for the gshare predictor: reset, prediction, training,
// JAL wrap, same-cycle repair, saturation and mid-stream reset.
module tb_gshare_param_ongorucu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        getir_gecerli = 1'b0;
    logic [31:0] getir_ps = '0;
    logic [31:0] getir_buyruk = '0;
    logic        yurut_gecerli = 1'b0;
    logic [31:0] yurut_ps = '0;
    logic [5:0]  yurut_ggy = '0;
    logic        yurut_dallan = 1'b0;
    logic        yurut_yanlis = 1'b0;
    logic        sonuc_dallan;
    logic [31:0] sonuc_dallan_ps;
    logic [5:0]  sonuc_ggy;
    logic [31:0] tahmin_sayaci;
    logic [31:0] yanlis_sayaci;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gshare_param_ongorucu dut (
        .clk             (clk),
        .rst             (rst),
        .getir_gecerli   (getir_gecerli),
        .getir_ps        (getir_ps),
        .getir_buyruk    (getir_buyruk),
        .yurut_gecerli   (yurut_gecerli),
        .yurut_ps        (yurut_ps),
        .yurut_ggy       (yurut_ggy),
        .yurut_dallan    (yurut_dallan),
        .yurut_yanlis    (yurut_yanlis),
        .sonuc_dallan    (sonuc_dallan),
        .sonuc_dallan_ps (sonuc_dallan_ps),
        .sonuc_ggy       (sonuc_ggy),
        .tahmin_sayaci   (tahmin_sayaci),
        .yanlis_sayaci   (yanlis_sayaci)
    );

    function automatic logic [31:0] enc_b(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic v, input logic [31:0] ps, input logic [31:0] ins);
        getir_gecerli = v;
        getir_ps      = ps;
        getir_buyruk  = ins;
    endtask

    task automatic resolve(input logic v, input logic [31:0] ps, input logic [5:0] g,
                           input logic d, input logic y);
        yurut_gecerli = v;
        yurut_ps      = ps;
        yurut_ggy     = g;
        yurut_dallan  = d;
        yurut_yanlis  = y;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] bi16;
        bi16 = enc_b(13'd16);

        #1 rst = 1'b0;
        #1;
        chk("rst_tahmin", tahmin_sayaci, 32'd0);
        chk("rst_yanlis", yanlis_sayaci, 32'd0);
        chk("rst_ggy", {26'd0, sonuc_ggy}, 32'd0);
        #4 rst = 1'b1;
        tick();

        fetch(1'b1, 32'h100, bi16);
        #1;
        chk("a_dallan", {31'd0, sonuc_dallan}, 32'd0);
        chk("a_ps", sonuc_dallan_ps, 32'h104);
        chk("a_ggy", {26'd0, sonuc_ggy}, 32'd0);
        tick();

        resolve(1'b1, 32'h100, 6'd0, 1'b1, 1'b0);
        #1;
        chk("b_old_ctr", {31'd0, sonuc_dallan}, 32'd0);
        chk("b_ps", sonuc_dallan_ps, 32'h104);
        tick();

        fetch(1'b0, 32'h200, bi16);
        #1;
        chk("c_inv_dallan", {31'd0, sonuc_dallan}, 32'd0);
        chk("c_inv_ps", sonuc_dallan_ps, 32'h204);
        tick();

        resolve(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
        fetch(1'b1, 32'h100, bi16);
        #1;
        chk("d_dallan", {31'd0, sonuc_dallan}, 32'd1);
        chk("d_ps", sonuc_dallan_ps, 32'h110);
        chk("d_ggy", {26'd0, sonuc_ggy}, 32'd0);
        chk("d_tahmin", tahmin_sayaci, 32'd2);
        tick();

        fetch(1'b1, 32'hFFFF_FFF0, enc_j(21'h20));
        #1;
        chk("e_jal_dallan", {31'd0, sonuc_dallan}, 32'd1);
        chk("e_jal_ps", sonuc_dallan_ps, 32'h10);
        chk("e_jal_ggy", {26'd0, sonuc_ggy}, 32'd1);
        tick();

        fetch(1'b0, 32'h0, 32'h0);
        #1;
        chk("f_nb_dallan", {31'd0, sonuc_dallan}, 32'd0);
        chk("f_nb_ps", sonuc_dallan_ps, 32'h4);
        chk("f_ggy", {26'd0, sonuc_ggy}, 32'd1);
        chk("f_tahmin", tahmin_sayaci, 32'd3);
        tick();

        fetch(1'b1, 32'h100, bi16);
        resolve(1'b1, 32'h300, 6'b101010, 1'b1, 1'b1);
        #1;
        chk("g_dallan", {31'd0, sonuc_dallan}, 32'd0);
        chk("g_ggy", {26'd0, sonuc_ggy}, 32'd1);
        tick();

        fetch(1'b0, 32'h0, 32'h0);
        resolve(1'b1, 32'h104, 6'd0, 1'b0, 1'b0);
        #1;
        chk("h_ggy", {26'd0, sonuc_ggy}, 32'h15);
        chk("h_tahmin", tahmin_sayaci, 32'd4);
        chk("h_yanlis", yanlis_sayaci, 32'd1);
        tick();
        tick();
        tick();
        tick();

        resolve(1'b1, 32'h104, 6'd0, 1'b1, 1'b0);
        tick();

        resolve(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
        fetch(1'b1, 32'h50, bi16);
        #1;
        chk("m_sat_dallan", {31'd0, sonuc_dallan}, 32'd0);
        chk("m_ps", sonuc_dallan_ps, 32'h54);
        tick();

        fetch(1'b0, 32'h0, 32'h0);
        resolve(1'b1, 32'h0, 6'h1F, 1'b1, 1'b1);
        #1;
        chk("n_ggy", {26'd0, sonuc_ggy}, 32'h2A);
        chk("n_tahmin", tahmin_sayaci, 32'd5);
        tick();

        resolve(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
        fetch(1'b1, 32'h100, bi16);
        #1;
        chk("o_ggy", {26'd0, sonuc_ggy}, 32'h3F);
        chk("o_yanlis", yanlis_sayaci, 32'd2);
        rst = 1'b0;
        #1;
        chk("o_rst_ggy", {26'd0, sonuc_ggy}, 32'd0);
        chk("o_rst_tahmin", tahmin_sayaci, 32'd0);
        chk("o_rst_yanlis", yanlis_sayaci, 32'd0);
        chk("o_rst_dallan", {31'd0, sonuc_dallan}, 32'd0);
        chk("o_rst_ps", sonuc_dallan_ps, 32'h104);
        tick();
        #1 rst = 1'b1;

        fetch(1'b0, 32'h0, 32'h0);
        resolve(1'b1, 32'h100, 6'd0, 1'b1, 1'b0);
        tick();
        tick();

        resolve(1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
        fetch(1'b1, 32'h100, bi16);
        #1;
        chk("r_dallan", {31'd0, sonuc_dallan}, 32'd1);
        chk("r_ps", sonuc_dallan_ps, 32'h110);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
